gate_exerciser: RTL and testbench

Self-test sequencer for a single 2-input gate datapath, such as the demux-built AND gate. On `start` it drives the gate under test through all four input combinations in order. For each combination it waits a programmable settle time, samples the gate output and compares it against a caller-supplied 4-entry truth table. It sits between a bench or top-level controller and any 2-input gate instance, and reports pass/fail, a mismatch count and a per-vector failure map.

---
 rtl/gate_ex_pkg.sv | 17 +
 rtl/gate_ex_settle_cnt.sv | 28 ++
 rtl/gate_exerciser.sv | 123 ++++++++++++
 tb/tb_gate_exerciser.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/gate_ex_pkg.sv
// Shared types and sizes for the gate_exerciser self-test sequencer.
package gate_ex_pkg;

    localparam int unsigned NUM_VECTORS = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned ERR_W       = 3;
    localparam int unsigned CNT_W       = 4;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        CHECK,
        DONE
    } state_t;

endpackage

// File: rtl/gate_ex_settle_cnt.sv
// Settle-time down-counter: load sets SETTLE_CYCLES, expire flags the last settle cycle.
module gate_ex_settle_cnt
    import gate_ex_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    output logic expire
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= CNT_W'(SETTLE_CYCLES);
        end else if (count != '0) begin
            count <= count - CNT_W'(1);
        end
    end

    // Expiring on a count of one makes SETTLE last exactly SETTLE_CYCLES cycles.
    assign expire = (count == CNT_W'(1));

endmodule

// File: rtl/gate_exerciser.sv
// Sequences a 2-input gate through all four input vectors and checks it against a truth table.
// Optional first-failure index capture is enabled by defining GATE_EX_FIRSTFAIL_EN.
module gate_exerciser
    import gate_ex_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [NUM_VECTORS-1:0] truth_table,
    output logic                   gate_a,
    output logic                   gate_b,
    input  logic                   gate_y,
    output logic                   busy,
    output logic                   done,
    output logic                   pass,
    output logic [ERR_W-1:0]       err_count,
    output logic [NUM_VECTORS-1:0] fail_vec
`ifdef GATE_EX_FIRSTFAIL_EN
    ,
    output logic [IDX_W-1:0]       first_fail
`endif
);

    state_t                 state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_VECTORS-1:0] table_q;
    logic                   load;
    logic                   expire;
    logic                   mismatch;

    assign load     = (state == DRIVE);
    assign mismatch = (gate_y != table_q[idx]);

    gate_ex_settle_cnt #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load),
        .expire(expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            table_q   <= '0;
            gate_a    <= 1'b0;
            gate_b    <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= '0;
            fail_vec  <= '0;
`ifdef GATE_EX_FIRSTFAIL_EN
            first_fail <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        table_q   <= truth_table;
                        err_count <= '0;
                        fail_vec  <= '0;
                        pass      <= 1'b0;
                        idx       <= '0;
                        gate_a    <= 1'b0;
                        gate_b    <= 1'b0;
                        busy      <= 1'b1;
`ifdef GATE_EX_FIRSTFAIL_EN
                        first_fail <= '0;
`endif
                        state     <= DRIVE;
                    end
                end
                DRIVE: begin
                    state <= (SETTLE_CYCLES == 0) ? CHECK : SETTLE;
                end
                SETTLE: begin
                    if (expire) begin
                        state <= CHECK;
                    end
                end
                CHECK: begin
                    if (mismatch) begin
                        fail_vec[idx] <= 1'b1;
                        if (err_count < ERR_W'(NUM_VECTORS)) begin
                            err_count <= err_count + ERR_W'(1);
                        end
`ifdef GATE_EX_FIRSTFAIL_EN
                        if (err_count == '0) begin
                            first_fail <= idx;
                        end
`endif
                    end
                    if (idx == IDX_W'(NUM_VECTORS - 1)) begin
                        // pass is registered alongside done so it already includes this last CHECK.
                        pass             <= (err_count == '0) && !mismatch;
                        done             <= 1'b1;
                        busy             <= 1'b0;
                        gate_a           <= 1'b0;
                        gate_b           <= 1'b0;
                        state            <= DONE;
                    end else begin
                        idx              <= idx + IDX_W'(1);
                        {gate_a, gate_b} <= idx + IDX_W'(1);
                        state            <= DRIVE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_exerciser.sv
// Randomized self-checking bench for gate_exerciser at SETTLE_CYCLES of 0 and 2.
module tb_gate_exerciser;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] start_v;
    logic [3:0] tt_v   [2];
    logic [3:0] gate_fn[2];
    logic [1:0] glitch;
    logic [1:0] ga, gb, gy, bz, dn, ps;
    logic [2:0] ec [2];
    logic [3:0] fv [2];
`ifdef GATE_EX_FIRSTFAIL_EN
    logic [1:0] ff [2];
`endif

    int unsigned n_vec  = 0;
    int unsigned n_miss = 0;

    always #5 clk = ~clk;

    // Behavioural gate under test: output looked up from a 4-entry function table.
    assign gy[0] = gate_fn[0][{ga[0], gb[0]}] ^ glitch[0];
    assign gy[1] = gate_fn[1][{ga[1], gb[1]}] ^ glitch[1];

    gate_exerciser #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .truth_table(tt_v[0]),
        .gate_a(ga[0]), .gate_b(gb[0]), .gate_y(gy[0]), .busy(bz[0]), .done(dn[0]),
        .pass(ps[0]), .err_count(ec[0]), .fail_vec(fv[0])
`ifdef GATE_EX_FIRSTFAIL_EN
        , .first_fail(ff[0])
`endif
    );

    gate_exerciser #(.SETTLE_CYCLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .truth_table(tt_v[1]),
        .gate_a(ga[1]), .gate_b(gb[1]), .gate_y(gy[1]), .busy(bz[1]), .done(dn[1]),
        .pass(ps[1]), .err_count(ec[1]), .fail_vec(fv[1])
`ifdef GATE_EX_FIRSTFAIL_EN
        , .first_fail(ff[1])
`endif
    );

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_idle_outputs(input int u, input string tag);
        check({tag, " gate_ab"}, {ga[u], gb[u]}, 0);
        check({tag, " busy"}, bz[u], 0);
        check({tag, " done"}, dn[u], 0);
        check({tag, " pass"}, ps[u], 0);
        check({tag, " err_count"}, ec[u], 0);
        check({tag, " fail_vec"}, fv[u], 0);
`ifdef GATE_EX_FIRSTFAIL_EN
        check({tag, " first_fail"}, ff[u], 0);
`endif
    endtask

    // u selects the DUT: 0 -> SETTLE_CYCLES=0, 1 -> SETTLE_CYCLES=2.
    task automatic run_vec(input int u, input logic [3:0] tt, input logic [3:0] fn, input string tag);
        int unsigned n   = (u == 0) ? 0 : 2;
        int unsigned len = 4 * (n + 2);
        int unsigned exp_err = 0;
        int unsigned exp_first = 0;
        bit          found = 0;
        logic [3:0]  exp_fv = '0;
        for (int i = 0; i < 4; i++) begin
            if (fn[i] != tt[i]) begin
                exp_fv[i] = 1'b1;
                exp_err++;
                if (!found) begin
                    exp_first = i;
                    found = 1;
                end
            end
        end
        gate_fn[u] = fn;
        @(negedge clk);
        start_v[u] = 1'b1;
        tt_v[u]    = tt;
        @(posedge clk);
        for (int k = 0; k < int'(len); k++) begin
            @(negedge clk);
            start_v[u] = 1'($urandom_range(0, 1));
            tt_v[u]    = 4'($urandom);
            glitch[u]  = ((k + 1) % (n + 2) != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            check({tag, " gate_ab"}, {ga[u], gb[u]}, k / (n + 2));
            check({tag, " busy"}, bz[u], 1);
            check({tag, " done early"}, dn[u], 0);
        end
        @(negedge clk);
        glitch[u]  = 1'b0;
        start_v[u] = 1'b1;
        check({tag, " done"}, dn[u], 1);
        check({tag, " busy in done"}, bz[u], 0);
        check({tag, " gate_ab in done"}, {ga[u], gb[u]}, 0);
        check({tag, " pass"}, ps[u], (exp_err == 0) ? 1 : 0);
        check({tag, " err_count"}, ec[u], exp_err);
        check({tag, " fail_vec"}, fv[u], exp_fv);
`ifdef GATE_EX_FIRSTFAIL_EN
        check({tag, " first_fail"}, ff[u], exp_first);
`endif
        @(negedge clk);
        start_v[u] = 1'b0;
        check({tag, " done once"}, dn[u], 0);
        check({tag, " busy after"}, bz[u], 0);
        check({tag, " pass held"}, ps[u], (exp_err == 0) ? 1 : 0);
        @(negedge clk);
        check({tag, " no restart from done"}, bz[u], 0);
        check({tag, " err held"}, ec[u], exp_err);
    endtask

    initial begin
        rst_n      = 1'b0;
        start_v    = '0;
        glitch     = '0;
        tt_v[0]    = '0;
        tt_v[1]    = '0;
        gate_fn[0] = 4'b1000;
        gate_fn[1] = 4'b1000;
        repeat (2) @(negedge clk);
        check_idle_outputs(0, "reset0");
        check_idle_outputs(1, "reset2");
        rst_n = 1'b1;
        @(negedge clk);

        run_vec(1, 4'b1000, 4'b1000, "and_s2");
        run_vec(0, 4'b1000, 4'b1000, "and_s0");
        run_vec(1, 4'b1000, 4'b0000, "stuck0_s2");
        run_vec(1, 4'b1000, 4'b1110, "or_s2");
        run_vec(0, 4'b1000, 4'b1110, "or_s0");
        run_vec(0, 4'b1111, 4'b0000, "allbad_s0");

        for (int r = 0; r < 20; r++) begin
            run_vec(r % 2, 4'($urandom), 4'($urandom), "random");
        end

        // Abort during SETTLE of vector 2 on the SETTLE_CYCLES=2 instance.
        gate_fn[1] = 4'b0110;
        @(negedge clk);
        start_v[1] = 1'b1;
        tt_v[1]    = 4'b1000;
        @(posedge clk);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            start_v[1] = 1'b0;
        end
        check("pre-abort gate_ab", {ga[1], gb[1]}, 2);
        rst_n = 1'b0;
        #1;
        check_idle_outputs(1, "abort");
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("abort no done", dn[1], 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs(1, "post-abort idle");
        run_vec(1, 4'b1000, 4'b1000, "post_abort");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
